// File: rtl/imem_responder.sv
// imem_responder: fetch-side responder that returns a stored word after
// WAIT_STATES cycles, supports cancel/restart and a boot-load write port.
// Ports: clk, rst (sync, active-low); req_valid/req_addr fetch request;
// cancel squashes the pending fetch; resp_valid/resp_data/resp_err
// registered response; busy combinational freeze; load_en/addr/data write.
module imem_responder #(
  parameter int WORD_LENGTH = 32,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [31:0]            req_addr,
  input  logic                   cancel,
  output logic                   resp_valid,
  output logic [WORD_LENGTH-1:0] resp_data,
  output logic                   resp_err,
  output logic                   busy,
  input  logic                   load_en,
  input  logic [31:0]            load_addr,
  input  logic [WORD_LENGTH-1:0] load_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t                 state;
  logic [3:0]             cnt;
  logic [DEPTH_LOG2-1:0]  idx;
  logic                   mis;
  logic [WORD_LENGTH-1:0] mem [DEPTH];

  logic [DEPTH_LOG2-1:0]  req_idx;
  logic [DEPTH_LOG2-1:0]  load_idx;
  logic                   req_mis;
  logic                   accept;

  assign req_idx  = req_addr[DEPTH_LOG2+1:2];
  assign load_idx = load_addr[DEPTH_LOG2+1:2];
  assign req_mis  = (req_addr[1:0] != 2'b00);

  // Upper address bits wrap away; load low bits carry no meaning.
  logic unused_bits;
  assign unused_bits = ^{req_addr[31:DEPTH_LOG2+2],
                         load_addr[31:DEPTH_LOG2+2],
                         load_addr[1:0]};

  // A new request is taken when idle, back-to-back from RESP,
  // or as a restart when it arrives together with cancel.
  always_comb begin
    accept = 1'b0;
    if (req_valid) begin
      accept = (state == IDLE) ||
               (state == RESP) ||
               (state == WAIT && cancel);
    end
  end

  assign busy = (state == WAIT) ||
                (req_valid && (state == IDLE ||
                               (state == RESP && WS != 4'd0)));

  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_idx] <= load_data;
    end
  end

  // Reads of mem here see the pre-write value on a same-edge load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      idx        <= '0;
      mis        <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      if (accept) begin
        idx <= req_idx;
        mis <= req_mis;
        cnt <= WS;
        if (WS == 4'd0) begin
          // No wait states: the latched index is not ready yet,
          // so read straight from the request address.
          state      <= RESP;
          resp_valid <= 1'b1;
          resp_data  <= mem[req_idx];
          resp_err   <= req_mis;
        end else begin
          state <= WAIT;
        end
      end else begin
        unique case (state)
          WAIT: begin
            if (cancel) begin
              state <= IDLE;
              cnt   <= 4'd0;
            end else if (cnt <= 4'd1) begin
              state      <= RESP;
              cnt        <= 4'd0;
              resp_valid <= 1'b1;
              resp_data  <= mem[idx];
              resp_err   <= mis;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed checks of latency, streaming, cancel,
// misalignment/wrap, read-before-write collision and mid-fetch reset.
module tb_imem_responder;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        cancel;
  logic        load_en;
  logic [31:0] load_addr;
  logic [31:0] load_data;

  logic        rv_a, re_a, busy_a;
  logic [31:0] rd_a;
  logic        rv_b, re_b, busy_b;
  logic [31:0] rd_b;
  logic        rv_c, re_c, busy_c;
  logic [31:0] rd_c;

  int checks;
  int failures;

  imem_responder #(
    .WORD_LENGTH(32), .DEPTH_LOG2(8), .WAIT_STATES(2)
  ) u_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr),
    .cancel(cancel),
    .resp_valid(rv_a), .resp_data(rd_a),
    .resp_err(re_a), .busy(busy_a),
    .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data)
  );

  imem_responder #(
    .WORD_LENGTH(32), .DEPTH_LOG2(8), .WAIT_STATES(0)
  ) u_b (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr),
    .cancel(cancel),
    .resp_valid(rv_b), .resp_data(rd_b),
    .resp_err(re_b), .busy(busy_b),
    .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data)
  );

  imem_responder #(
    .WORD_LENGTH(32), .DEPTH_LOG2(8), .WAIT_STATES(3)
  ) u_c (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr),
    .cancel(cancel),
    .resp_valid(rv_c), .resp_data(rd_c),
    .resp_err(re_c), .busy(busy_c),
    .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic load(input logic [31:0] a,
                      input logic [31:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    req_valid = 1'b0;
    cancel    = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // Bounded wait for a response on the WAIT_STATES=2 instance.
  task automatic wait_a(output int n);
    n = 0;
    while (!rv_a && n < 10) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int pulses;
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    req_valid = 1'b0;
    req_addr  = 32'h0;
    cancel    = 1'b0;
    load_en   = 1'b0;
    load_addr = 32'h0;
    load_data = 32'h0;

    load(32'h10, 32'hE3A01005);
    load(32'h00, 32'h11111111);
    load(32'h04, 32'h22222222);
    load(32'h08, 32'h33333333);
    load(32'h20, 32'hBBBBBBBB);
    load(32'h40, 32'hAAAA5555);

    // Reset state
    do_reset();
    check("rst_rv", rv_a, 0);
    check("rst_data", rd_a, 0);
    check("rst_err", re_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_data_b", rd_b, 0);

    // Latency, WAIT_STATES=2
    req_valid = 1'b1;
    req_addr  = 32'h10;
    settle();
    check("lat_busy_req", busy_a, 1);
    tick();
    req_valid = 1'b0;
    settle();
    check("lat_busy_w1", busy_a, 1);
    check("lat_rv_w1", rv_a, 0);
    tick();
    check("lat_busy_w2", busy_a, 1);
    check("lat_rv_w2", rv_a, 0);
    tick();
    check("lat_rv", rv_a, 1);
    check("lat_data", rd_a, 32'hE3A01005);
    check("lat_err", re_a, 0);
    check("lat_busy_resp", busy_a, 0);
    tick();
    check("lat_rv_off", rv_a, 0);
    check("lat_hold", rd_a, 32'hE3A01005);

    // Streaming, WAIT_STATES=0
    do_reset();
    req_valid = 1'b1;
    req_addr  = 32'h0;
    settle();
    check("str_busy_idle", busy_b, 1);
    tick();
    req_addr = 32'h4;
    settle();
    check("str_rv0", rv_b, 1);
    check("str_d0", rd_b, 32'h11111111);
    check("str_busy0", busy_b, 0);
    tick();
    req_addr = 32'h8;
    settle();
    check("str_rv1", rv_b, 1);
    check("str_d1", rd_b, 32'h22222222);
    check("str_busy1", busy_b, 0);
    tick();
    req_valid = 1'b0;
    settle();
    check("str_rv2", rv_b, 1);
    check("str_d2", rd_b, 32'h33333333);
    check("str_busy2", busy_b, 0);
    tick();
    check("str_rv_off", rv_b, 0);

    // Cancel and restart, WAIT_STATES=3
    do_reset();
    req_valid = 1'b1;
    req_addr  = 32'h20;
    tick();
    cancel   = 1'b1;
    req_addr = 32'h40;
    settle();
    check("cr_busy", busy_c, 1);
    tick();
    cancel    = 1'b0;
    req_valid = 1'b0;
    settle();
    check("cr_rv_r0", rv_c, 0);
    tick();
    check("cr_rv_r1", rv_c, 0);
    tick();
    check("cr_rv_r2", rv_c, 0);
    tick();
    check("cr_rv", rv_c, 1);
    check("cr_data", rd_c, 32'hAAAA5555);
    tick();
    check("cr_rv_off", rv_c, 0);

    // Cancel only: fetch dropped, no response
    do_reset();
    req_valid = 1'b1;
    req_addr  = 32'h20;
    tick();
    req_valid = 1'b0;
    cancel    = 1'b1;
    tick();
    cancel = 1'b0;
    settle();
    check("co_busy", busy_c, 0);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (rv_c) pulses++;
      tick();
    end
    check("co_pulses", pulses, 0);
    check("co_data", rd_c, 0);

    // Misaligned + wrap
    load(32'h00, 32'hDEADBEEF);
    load(32'h08, 32'h00000000);
    do_reset();
    req_valid = 1'b1;
    req_addr  = 32'h402;
    tick();
    req_valid = 1'b0;
    wait_a(n);
    check("mis_lat", n, 2);
    check("mis_rv", rv_a, 1);
    check("mis_data", rd_a, 32'hDEADBEEF);
    check("mis_err", re_a, 1);

    // Collision: load on the RESP-entry edge
    do_reset();
    req_valid = 1'b1;
    req_addr  = 32'h8;
    tick();
    req_valid = 1'b0;
    tick();
    load_en   = 1'b1;
    load_addr = 32'h8;
    load_data = 32'h12345678;
    tick();
    load_en = 1'b0;
    check("col_rv", rv_a, 1);
    check("col_old", rd_a, 32'h00000000);
    check("col_err", re_a, 0);
    req_valid = 1'b1;
    req_addr  = 32'h8;
    tick();
    req_valid = 1'b0;
    wait_a(n);
    check("ref_lat", n, 2);
    check("ref_data", rd_a, 32'h12345678);

    // Reset during WAIT
    do_reset();
    req_valid = 1'b1;
    req_addr  = 32'h10;
    tick();
    req_valid = 1'b0;
    tick();
    check("mr_busy_wait", busy_a, 1);
    rst = 1'b0;
    tick();
    check("mr_rv", rv_a, 0);
    check("mr_data", rd_a, 0);
    check("mr_err", re_a, 0);
    check("mr_busy", busy_a, 0);
    rst = 1'b1;
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rv_a) pulses++;
    end
    check("mr_pulses", pulses, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
